// File: rtl/huff_bit_serializer.sv
// huff_bit_serializer
//
// Bit-serial output stage of the Huffman encoder. Takes one right-justified
// variable-length codeword plus its length, then shifts it out MSB-first, one
// bit per serial handshake. An internal bit counter rolls over at the codeword
// length, which marks the end of the word and frees the block for the next one.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst           synchronous active-high reset, aborts any word in flight
//   code_valid    upstream presents a codeword on code_bits/code_len
//   code_ready    block can accept a codeword this cycle (IDLE and not in reset)
//   code_bits     right-justified codeword, bit code_len-1 goes out first
//   code_len      codeword length, legal range 1..MAX_LEN
//   serial_out    current output bit
//   serial_valid  serial_out is valid
//   serial_ready  downstream takes serial_out this cycle
//   bit_count     bits of the current codeword already transferred
//   done_pulse    one-cycle pulse after the last bit of a codeword transfers
//   len_err       one-cycle pulse after an illegal-length word was discarded

module huff_bit_serializer #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               code_valid,
    output logic               code_ready,
    input  logic [MAX_LEN-1:0] code_bits,
    input  logic [LEN_W-1:0]   code_len,
    output logic               serial_out,
    output logic               serial_valid,
    input  logic               serial_ready,
    output logic [LEN_W-1:0]   bit_count,
    output logic               done_pulse,
    output logic               len_err
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   ONE_L     = LEN_W'(1);
    localparam logic [MAX_LEN-1:0] BIT0_L    = MAX_LEN'(1);

    state_t             state;
    logic [MAX_LEN-1:0] shift_reg;
    logic [LEN_W-1:0]   len_reg;

    logic accept;
    logic len_ok;
    logic transfer;
    logic last_bit;
    logic first_bit;
    logic next_bit;

    assign code_ready = (state == IDLE) && !rst;
    assign accept     = code_valid && code_ready;
    assign len_ok     = (code_len != '0) && (code_len <= MAX_LEN_L);
    assign transfer   = serial_valid && serial_ready;
    assign last_bit   = (bit_count == (len_reg - ONE_L));

    // Bit selection is done with a one-hot mask rather than a variable part
    // select, so an out-of-range length can never produce an out-of-range index.
    // next_bit is only consumed when the current bit is not the last one, so
    // len_reg-1-(bit_count+1) is always within 0..len_reg-2 when it matters.
    assign first_bit = |(code_bits & (BIT0_L << (code_len - ONE_L)));
    assign next_bit  = |(shift_reg & (BIT0_L << (len_reg - ONE_L - (bit_count + ONE_L))));

    // Single-process FSM. serial_out and serial_valid are registered and are
    // preloaded with the next bit, so they hold naturally under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shift_reg    <= '0;
            len_reg      <= '0;
            bit_count    <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            done_pulse   <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            len_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (len_ok) begin
                            shift_reg    <= code_bits;
                            len_reg      <= code_len;
                            bit_count    <= '0;
                            serial_out   <= first_bit;
                            serial_valid <= 1'b1;
                            state        <= SHIFT;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (transfer) begin
                        if (last_bit) begin
                            bit_count    <= '0;
                            serial_out   <= 1'b0;
                            serial_valid <= 1'b0;
                            done_pulse   <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            bit_count  <= bit_count + ONE_L;
                            serial_out <= next_bit;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huff_bit_serializer.sv
// tb_huff_bit_serializer
//
// Directed bench for huff_bit_serializer. Inputs change #1 after the rising
// edge and outputs are checked in the same window, so every check sees the
// registered state produced by the preceding edge.

module tb_huff_bit_serializer;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;

    logic               tb_clk;
    logic               rst;
    logic               code_valid;
    logic               code_ready;
    logic [MAX_LEN-1:0] code_bits;
    logic [LEN_W-1:0]   code_len;
    logic               serial_out;
    logic               serial_valid;
    logic               serial_ready;
    logic [LEN_W-1:0]   bit_count;
    logic               done_pulse;
    logic               len_err;

    int passed_count;
    int fail_count;
    int total_count;

    huff_bit_serializer #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W)
    ) dut (
        .clk         (tb_clk),
        .rst         (rst),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .code_bits   (code_bits),
        .code_len    (code_len),
        .serial_out  (serial_out),
        .serial_valid(serial_valid),
        .serial_ready(serial_ready),
        .bit_count   (bit_count),
        .done_pulse  (done_pulse),
        .len_err     (len_err)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Advance one clock edge and settle just past it.
    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_count++;
        assert (observed === expected) begin
            passed_count++;
        end else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Check the serial side of the DUT in one call.
    task automatic check_serial(input string tag, input logic exp_valid, input logic exp_out,
                                input logic [LEN_W-1:0] exp_count, input logic exp_done);
        check({tag, ".valid"}, 32'(serial_valid), 32'(exp_valid));
        check({tag, ".out"},   32'(serial_out),   32'(exp_out));
        check({tag, ".count"}, 32'(bit_count),    32'(exp_count));
        check({tag, ".done"},  32'(done_pulse),   32'(exp_done));
    endtask

    initial begin
        logic [15:0] long_code;
        logic [5:0]  bp_ready;
        logic [5:0]  bp_out;
        logic [1:0]  bp_count [6];
        logic [3:0]  basic_bits;

        passed_count = 0;
        fail_count   = 0;
        total_count  = 0;

        rst          = 1'b1;
        code_valid   = 1'b1;
        code_bits    = 16'h000B;
        code_len     = 5'd4;
        serial_ready = 1'b1;

        // Reset held for two edges with code_valid asserted.
        step();
        check("rst1.ready", 32'(code_ready), 32'd0);
        check_serial("rst1", 1'b0, 1'b0, 5'd0, 1'b0);
        check("rst1.len_err", 32'(len_err), 32'd0);
        step();
        check("rst2.ready", 32'(code_ready), 32'd0);
        check_serial("rst2", 1'b0, 1'b0, 5'd0, 1'b0);
        rst        = 1'b0;
        code_valid = 1'b0;
        #1;
        check("rst_rel.ready", 32'(code_ready), 32'd1);

        // Basic 4-bit code 1011.
        basic_bits = 4'b1011;
        code_valid = 1'b1;
        code_bits  = 16'h000B;
        code_len   = 5'd4;
        step();
        code_valid = 1'b0;
        code_bits  = 16'hFFFF;
        code_len   = 5'd9;
        for (int k = 0; k < 4; k++) begin
            check_serial($sformatf("basic.b%0d", k), 1'b1, basic_bits[3-k], LEN_W'(k), 1'b0);
            check($sformatf("basic.ready%0d", k), 32'(code_ready), 32'd0);
            step();
        end
        check_serial("basic.end", 1'b0, 1'b0, 5'd0, 1'b1);
        check("basic.end.ready", 32'(code_ready), 32'd1);

        // Backpressure: code 110, ready pattern 1,0,0,1,0,1.
        code_valid   = 1'b1;
        code_bits    = 16'h0006;
        code_len     = 5'd3;
        serial_ready = 1'b0;
        step();
        code_valid = 1'b0;
        bp_ready    = 6'b101001;
        bp_out      = 6'b001111;
        bp_count[0] = 2'd0;
        bp_count[1] = 2'd1;
        bp_count[2] = 2'd1;
        bp_count[3] = 2'd1;
        bp_count[4] = 2'd2;
        bp_count[5] = 2'd2;
        for (int c = 0; c < 6; c++) begin
            serial_ready = bp_ready[c];
            check_serial($sformatf("bp.c%0d", c), 1'b1, bp_out[c], LEN_W'(bp_count[c]), 1'b0);
            step();
        end
        serial_ready = 1'b1;
        check_serial("bp.end", 1'b0, 1'b0, 5'd0, 1'b1);

        // Length 16, code A5C3, then length 1 back to back.
        long_code  = 16'b1010_0101_1100_0011;
        code_valid = 1'b1;
        code_bits  = 16'hA5C3;
        code_len   = 5'd16;
        step();
        code_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check_serial($sformatf("len16.b%0d", k), 1'b1, long_code[15-k], LEN_W'(k), 1'b0);
            step();
        end
        check_serial("len16.end", 1'b0, 1'b0, 5'd0, 1'b1);
        check("len16.end.ready", 32'(code_ready), 32'd1);
        code_valid = 1'b1;
        code_bits  = 16'h0001;
        code_len   = 5'd1;
        step();
        code_valid = 1'b0;
        check_serial("len1.b0", 1'b1, 1'b1, 5'd0, 1'b0);
        step();
        check_serial("len1.end", 1'b0, 1'b0, 5'd0, 1'b1);

        // Illegal lengths 0 and 17, accepted on consecutive edges.
        code_valid = 1'b1;
        code_bits  = 16'h00FF;
        code_len   = 5'd0;
        step();
        check("ill0.len_err", 32'(len_err), 32'd1);
        check("ill0.ready", 32'(code_ready), 32'd1);
        check_serial("ill0", 1'b0, 1'b0, 5'd0, 1'b0);
        code_len = 5'd17;
        step();
        code_valid = 1'b0;
        check("ill17.len_err", 32'(len_err), 32'd1);
        check("ill17.ready", 32'(code_ready), 32'd1);
        check_serial("ill17", 1'b0, 1'b0, 5'd0, 1'b0);
        step();
        check("ill.after.len_err", 32'(len_err), 32'd0);
        check_serial("ill.after", 1'b0, 1'b0, 5'd0, 1'b0);

        // Reset in the middle of an 8-bit word.
        code_valid = 1'b1;
        code_bits  = 16'h00FF;
        code_len   = 5'd8;
        step();
        code_valid = 1'b0;
        check_serial("mid.b0", 1'b1, 1'b1, 5'd0, 1'b0);
        step();
        step();
        check_serial("mid.b2", 1'b1, 1'b1, 5'd2, 1'b0);
        rst = 1'b1;
        step();
        check("mid.rst.ready", 32'(code_ready), 32'd0);
        check_serial("mid.rst", 1'b0, 1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        #1;
        check("mid.rel.ready", 32'(code_ready), 32'd1);
        code_valid = 1'b1;
        code_bits  = 16'h0001;
        code_len   = 5'd2;
        step();
        code_valid = 1'b0;
        check_serial("post.b0", 1'b1, 1'b0, 5'd0, 1'b0);
        step();
        check_serial("post.b1", 1'b1, 1'b1, 5'd1, 1'b0);
        step();
        check_serial("post.end", 1'b0, 1'b0, 5'd0, 1'b1);
        step();
        check("post.done_clear", 32'(done_pulse), 32'd0);

        $display("%0d/%0d checks passed", passed_count, total_count);
        $finish;
    end

endmodule
